// File: rtl/pc_sequencer_if.sv
// Instruction-fetch control bundle between the program-counter sequencer and the
// decode/memory side. The master drives the instruction fields and stall; the slave returns PC status.
interface pc_sequencer_if;
    logic [7:0]  OPCODE;
    logic [7:0]  OFFSET;
    logic        ZERO;
    logic        BUSYWAIT;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        WRITE_HOLD;
    logic        BR_TAKEN;
    logic        HALTED;

    modport master (
        output OPCODE, OFFSET, ZERO, BUSYWAIT,
        input  PC, PC_VALID, WRITE_HOLD, BR_TAKEN, HALTED
    );

    modport slave (
        input  OPCODE, OFFSET, ZERO, BUSYWAIT,
        output PC, PC_VALID, WRITE_HOLD, BR_TAKEN, HALTED
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, relative jumps/branches, memory stalls and halt.
// No valid/ready handshake here: BUSYWAIT=1 means the current instruction is not complete, so PC holds.
module pc_sequencer #(
    parameter logic [7:0] OP_J    = 8'h06,
    parameter logic [7:0] OP_BEQ  = 8'h07,
    parameter logic [7:0] OP_BNE  = 8'h08,
    parameter logic [7:0] OP_HALT = 8'hFF
) (
    input  logic              CLK,
    input  logic              RESET,
    pc_sequencer_if.slave     bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        br_taken_q, br_taken_d;
    logic        halted_q, halted_d;

    logic        taken;
    logic [31:0] offset_bytes;
    logic [31:0] next_pc;

    assign taken = (bus.OPCODE == OP_J)
                 || ((bus.OPCODE == OP_BEQ) &&  bus.ZERO)
                 || ((bus.OPCODE == OP_BNE) && !bus.ZERO);

    // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
    assign offset_bytes = {{22{bus.OFFSET[7]}}, bus.OFFSET, 2'b00};
    assign next_pc      = pc_q + 32'd4 + (taken ? offset_bytes : 32'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= BOOT;
            pc_q       <= 32'd0;
            pc_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            br_taken_q <= br_taken_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        br_taken_d = 1'b0;
        halted_d   = halted_q;
        case (state_q)
            BOOT: begin
                pc_d       = 32'd0;
                pc_valid_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                // A stall beats both halt and redirect: the instruction is not complete yet.
                if (bus.BUSYWAIT) begin
                    state_d = STALL;
                end else if (bus.OPCODE == OP_HALT) begin
                    state_d    = HALT;
                    halted_d   = 1'b1;
                    pc_valid_d = 1'b0;
                end else begin
                    pc_d       = next_pc;
                    br_taken_d = taken;
                end
            end
            STALL: begin
                if (!bus.BUSYWAIT) begin
                    pc_d       = next_pc;
                    br_taken_d = taken;
                    state_d    = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.PC         = pc_q;
    assign bus.PC_VALID   = pc_valid_q;
    assign bus.BR_TAKEN   = br_taken_q;
    assign bus.HALTED     = halted_q;
    assign bus.WRITE_HOLD = (state_q != RUN);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a behavioural model predicts each post-edge output set,
// a monitor compares the DUT against the queued predictions one cycle at a time.
module tb_pc_sequencer;

    localparam logic [7:0] OP_J    = 8'h06;
    localparam logic [7:0] OP_BEQ  = 8'h07;
    localparam logic [7:0] OP_BNE  = 8'h08;
    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam int         W       = 36;

    logic       CLK;
    logic       RESET;
    logic [1:0] dbg_state;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .OP_J   (OP_J),
        .OP_BEQ (OP_BEQ),
        .OP_BNE (OP_BNE),
        .OP_HALT(OP_HALT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard: {PC, PC_VALID, BR_TAKEN, HALTED, WRITE_HOLD}
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [31:0] m_pc;
    bit          m_booting, m_stalled, m_halted, m_valid, m_br;

    task automatic model_step(input bit rst, input logic [7:0] op, input logic [7:0] off,
                              input bit zero, input bit bw);
        bit redirect;
        int delta;
        if (rst) begin
            m_pc = 0; m_booting = 1; m_stalled = 0; m_halted = 0; m_valid = 0; m_br = 0;
        end else if (m_booting) begin
            m_pc = 0; m_booting = 0; m_valid = 1; m_br = 0;
        end else if (m_halted) begin
            m_br = 0;
        end else if (bw) begin
            m_stalled = 1; m_br = 0;
        end else if (!m_stalled && op == OP_HALT) begin
            m_halted = 1; m_valid = 0; m_br = 0;
        end else begin
            redirect = (op == OP_J) || (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
            delta    = redirect ? 4 * $signed(off) : 0;
            m_pc     = m_pc + 32'd4 + 32'(delta);
            m_br     = redirect;
            m_stalled = 0;
        end
    endtask

    // driver: apply inputs mid-cycle, predict the state after the coming rising edge
    task automatic drive(input bit rst, input logic [7:0] op, input logic [7:0] off,
                         input bit zero, input bit bw);
        bit hold;
        @(negedge CLK);
        RESET        = rst;
        bus.OPCODE   = op;
        bus.OFFSET   = off;
        bus.ZERO     = zero;
        bus.BUSYWAIT = bw;
        model_step(rst, op, off, zero, bw);
        hold = m_booting || m_stalled || m_halted;
        exp_q.push_back({m_pc, m_valid, m_br, m_halted, hold});
    endtask

    task automatic nop();
        drive(0, 8'h00, 8'h00, 0, 0);
    endtask

    // monitor: every edge produces a new output set
    always @(posedge CLK) begin
        logic [W-1:0] got, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {bus.PC, bus.PC_VALID, bus.BR_TAKEN, bus.HALTED, bus.WRITE_HOLD};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL outputs t=%0t got pc=%h valid=%b br=%b halted=%b hold=%b exp pc=%h valid=%b br=%b halted=%b hold=%b",
                         $time, got[35:4], got[3], got[2], got[1], got[0],
                         exp[35:4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    end

    initial begin
        logic [7:0] op;
        int         sel;
        RESET = 1'b1;
        bus.OPCODE = 8'h00; bus.OFFSET = 8'h00; bus.ZERO = 1'b0; bus.BUSYWAIT = 1'b0;

        // reset, boot, sequential fetch 0,0,4,8
        drive(1, 8'h00, 8'h00, 0, 0);
        nop(); nop(); nop();
        // jump +2 words from 0x08 -> 0x14, then pulse clears
        drive(0, OP_J, 8'h02, 0, 0);
        // BEQ -2 taken -> 0x10
        drive(0, OP_BEQ, 8'hFE, 1, 0);
        // 3 stalled edges at 0x10, then release -> 0x14
        drive(0, OP_J, 8'h40, 0, 1);
        drive(0, OP_HALT, 8'h40, 1, 1);
        drive(0, OP_BEQ, 8'h40, 1, 1);
        nop();
        // BEQ not taken -> 0x18; BNE taken with ZERO=0 -> 0x14; BNE not taken -> 0x18
        drive(0, OP_BEQ, 8'hFE, 0, 0);
        drive(0, OP_BNE, 8'hFE, 0, 0);
        drive(0, OP_BNE, 8'hFE, 1, 0);
        nop(); nop();
        // halt at 0x20 and stay frozen through random inputs
        drive(0, OP_HALT, 8'h00, 0, 0);
        for (int i = 0; i < 12; i++)
            drive(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        // reset mid-halt, boot, backward wrap from 0 with offset -128
        drive(1, OP_J, 8'h00, 0, 1);
        nop();
        drive(0, OP_J, 8'h80, 0, 0);
        nop();
        // reset while stalled
        drive(0, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h00, 8'h00, 0, 1);
        drive(1, OP_J, 8'h05, 0, 1);
        nop();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 25)      op = OP_J;
            else if (sel < 45) op = OP_BEQ;
            else if (sel < 65) op = OP_BNE;
            else if (sel < 67) op = OP_HALT;
            else               op = 8'($urandom_range(0, 254));
            drive(($urandom_range(0, 63) == 0), op, 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
